// File: rtl/kernel_rotator.sv
// kernel_rotator: buffers one SIZE x SIZE matrix, then streams it
// back out rotated by 0/90/180/270 degrees clockwise.
module kernel_rotator #(
  parameter int SIZE  = 7,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(SIZE);
  localparam int NE = SIZE * SIZE;
  localparam int IW = $clog2(NE);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic {
    LOAD,
    DRAIN
  } state_t;

  state_t           state;
  logic [CW-1:0]    row;
  logic [CW-1:0]    col;
  logic [1:0]       mode_q;
  logic             armed;
  logic [WIDTH-1:0] mem [NE];

  logic          acc;
  logic          fire;
  logic          at_end;
  logic [CW-1:0] sr;
  logic [CW-1:0] sc;
  logic [IW-1:0] widx;
  logic [IW-1:0] ridx;

  assign in_ready  = en & armed & (state == LOAD);
  assign out_valid = en & (state == DRAIN);
  assign acc       = in_valid & in_ready;
  assign fire      = out_valid & out_ready;
  assign at_end    = (row == LAST) && (col == LAST);
  assign out_last  = out_valid & at_end;
  assign busy      = (state == DRAIN) | (row != '0) | (col != '0);

  assign widx = IW'(row) * IW'(SIZE) + IW'(col);
  assign ridx = IW'(sr) * IW'(SIZE) + IW'(sc);

  assign out_data = out_valid ? mem[ridx] : '0;

  // Map the output position to its source element for the latched mode
  always_comb begin
    sr = row;
    sc = col;
    unique case (mode_q)
      2'd1: begin
        sr = LAST - col;
        sc = row;
      end
      2'd2: begin
        sr = LAST - row;
        sc = LAST - col;
      end
      2'd3: begin
        sr = col;
        sc = LAST - row;
      end
      default: begin
        sr = row;
        sc = col;
      end
    endcase
  end

  // Load/drain sequencing, shared row/col walk, mode latch, done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= LOAD;
      row    <= '0;
      col    <= '0;
      mode_q <= 2'd0;
      armed  <= 1'b0;
      done   <= 1'b0;
    end else begin
      armed <= 1'b1;
      done  <= 1'b0;
      if (acc || fire) begin
        if (col == LAST) begin
          col <= '0;
          row <= (row == LAST) ? '0 : row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (acc) begin
        if (row == '0 && col == '0)
          mode_q <= mode;
        if (at_end)
          state <= DRAIN;
      end
      if (fire && at_end) begin
        state <= LOAD;
        done  <= 1'b1;
      end
    end
  end

  // Matrix storage, written in row-major order during load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NE; i++)
        mem[i] <= '0;
    end else if (acc) begin
      mem[widx] <= in_data;
    end
  end

endmodule

// File: tb/tb_kernel_rotator.sv
// tb_kernel_rotator: table-driven and randomized checks of
// kernel_rotator (SIZE=3) against a matrix-level reference model.
module tb_kernel_rotator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;
  logic        done;

  kernel_rotator #(.SIZE(3), .WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [31:0] a [9];
  logic [31:0] rot [9];
  int          cnt = 0;
  bit          draining = 0;
  bit          armed_m = 0;
  bit          done_m = 0;
  logic [1:0]  lmode = 0;
  bit          last_acc = 0;
  logic [31:0] cap [$];

  typedef struct packed {
    logic [1:0]  m0;
    logic [3:0]  sw;
    logic [1:0]  m1;
    logic [35:0] exp;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // rotate 90 clockwise lmode times
  function automatic void build_rot();
    logic [31:0] m [3][3];
    logic [31:0] t [3][3];
    for (int i = 0; i < 9; i++) m[i/3][i%3] = a[i];
    for (int k = 0; k < int'(lmode); k++) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          t[r][c] = m[2-c][r];
      m = t;
    end
    for (int i = 0; i < 9; i++) rot[i] = m[i/3][i%3];
  endfunction

  task automatic step(input bit e, input bit iv, input logic [31:0] d,
                      input bit ordy, input logic [1:0] md);
    bit eir, eov, acc, fire;
    logic [31:0] eod;
    en = e;
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    mode = md;
    #1;
    eir = armed_m && e && !draining;
    eov = e && draining;
    eod = eov ? rot[cnt] : 32'd0;
    chk("in_ready", 32'(in_ready), 32'(eir));
    chk("out_valid", 32'(out_valid), 32'(eov));
    chk("out_data", out_data, eod);
    chk("out_last", 32'(out_last), 32'(eov && cnt == 8));
    chk("busy", 32'(busy), 32'(draining || cnt > 0));
    chk("done", 32'(done), 32'(done_m));
    if (out_valid && ordy) cap.push_back(out_data);
    acc = eir && iv;
    fire = eov && ordy;
    last_acc = acc;
    @(posedge clk);
    done_m = 0;
    armed_m = 1;
    if (acc) begin
      if (cnt == 0) lmode = md;
      a[cnt] = d;
      cnt++;
      if (cnt == 9) begin
        build_rot();
        draining = 1;
        cnt = 0;
      end
    end else if (fire) begin
      cnt++;
      if (cnt == 9) begin
        draining = 0;
        cnt = 0;
        done_m = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    en = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    cnt = 0;
    draining = 0;
    armed_m = 0;
    done_m = 0;
    lmode = 0;
    cap.delete();
    @(posedge clk);
    #1;
    chk("rst_hold_ready", 32'(in_ready), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic load_seq(input int from, input int upto,
                          input logic [1:0] m0, input int sw,
                          input logic [1:0] m1);
    for (int i = from; i < upto; i++) begin
      int tries = 0;
      do begin
        step(1, 1, 32'(i), 0, (i >= sw) ? m1 : m0);
        tries++;
      end while (!last_acc && tries < 20);
      if (!last_acc) chk("accept_timeout", 0, 1);
    end
  endtask

  task automatic drain(input int n);
    int t = 0;
    while (cap.size() < n && t < 60) begin
      step(1, 0, 0, 1, 0);
      t++;
    end
    if (cap.size() < n) chk("drain_timeout", 32'(cap.size()), 32'(n));
    step(1, 0, 0, 1, 0);
  endtask

  task automatic cmp_seq(input string nm, input logic [35:0] e);
    logic [31:0] v;
    for (int i = 0; i < 9; i++) begin
      v = (cap.size() > 0) ? cap.pop_front() : 32'hFFFF_FFFF;
      chk(nm, v, {28'd0, e[35-4*i -: 4]});
    end
    cap.delete();
  endtask

  initial begin
    tbl[0] = '{2'd0, 4'd9, 2'd0, 36'h012345678};
    tbl[1] = '{2'd1, 4'd9, 2'd1, 36'h630741852};
    tbl[2] = '{2'd3, 4'd9, 2'd3, 36'h258147036};
    tbl[3] = '{2'd2, 4'd3, 2'd0, 36'h876543210};

    do_reset();

    for (int k = 0; k < 4; k++) begin
      load_seq(0, 9, tbl[k].m0, int'(tbl[k].sw), tbl[k].m1);
      drain(9);
      cmp_seq($sformatf("tbl%0d", k), tbl[k].exp);
    end

    // backpressure on the first output of a 180 rotation
    load_seq(0, 9, 2'd2, 9, 2'd2);
    step(1, 0, 0, 0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 2'd0);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      en = 1'b1;
      out_ready = 1'b0;
      #1;
      chk("stall_data", out_data, 32'd8);
      chk("stall_last", 32'(out_last), 0);
      step(1, 0, 0, 0, 2'd0);
    end
    drain(9);
    cmp_seq("stall_seq", 36'h876543210);

    // enable dropped after the fourth input
    load_seq(0, 4, 2'd0, 9, 2'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h99, 1, 2'd1);
    load_seq(4, 9, 2'd1, 9, 2'd1);
    drain(9);
    cmp_seq("en_seq", 36'h012345678);

    // reset in the middle of a load
    load_seq(0, 5, 2'd3, 9, 2'd3);
    do_reset();
    load_seq(0, 9, 2'd0, 9, 2'd0);
    drain(9);
    cmp_seq("rst_seq", 36'h012345678);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
           $urandom, $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)));
    end
    cap.delete();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
